// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared types, width encodings and helpers for memory_stage
package memory_stage_pkg;

  localparam int unsigned XLEN = 64;

  // One-hot access width {D,W,H,B}
  localparam logic [3:0] WIDTH_B = 4'b0001;
  localparam logic [3:0] WIDTH_H = 4'b0010;
  localparam logic [3:0] WIDTH_W = 4'b0100;
  localparam logic [3:0] WIDTH_D = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RSP = 2'd1,
    ST_HOLD     = 2'd2
  } mem_state_e;

  function automatic logic [7:0] width_mask(input logic [3:0] width_1h);
    logic [7:0] m;
    m = 8'h00;
    unique case (1'b1)
      width_1h[0]: m = 8'h01;
      width_1h[1]: m = 8'h03;
      width_1h[2]: m = 8'h0F;
      width_1h[3]: m = 8'hFF;
      default:     m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [3:0] width_1h, input logic [2:0] off);
    return (width_1h[1] & off[0]) |
           (width_1h[2] & (off[1:0] != 2'b00)) |
           (width_1h[3] & (off != 3'b000));
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - data-memory req/gnt/rvalid port bundle
interface memory_stage_if;
  import memory_stage_pkg::*;

  logic            req;
  logic            gnt;
  logic            we;
  logic [7:0]      be;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/memory_stage_load_align_unit.sv
// rtl/memory_stage_load_align_unit.sv - combinational load data alignment and extension
module load_align_unit
  import memory_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      off_i,
  input  logic [3:0]      width_1h_i,
  input  logic            sign_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] raw;

  assign raw = rdata_i >> {off_i, 3'b000};

  always_comb begin
    result_o = raw;
    unique case (1'b1)
      width_1h_i[0]: result_o = {{56{sign_i & raw[7]}},  raw[7:0]};
      width_1h_i[1]: result_o = {{48{sign_i & raw[15]}}, raw[15:0]};
      width_1h_i[2]: result_o = {{32{sign_i & raw[31]}}, raw[31:0]};
      width_1h_i[3]: result_o = raw;
      default:       result_o = raw;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline memory stage: load/store over req/gnt/rvalid, registered rd results
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,

  input  logic            valid_i,
  input  logic [XLEN-1:0] alu_res_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] rd_data_i,
  input  logic [4:0]      rd_idx_i,
  input  logic            rd_wr_en_i,
  input  logic [3:0]      mem_width_1h_i,
  input  logic            mem_rd_i,
  input  logic            mem_wr_i,
  input  logic            mem_sign_i,

  memory_stage_if.master  dmem,

  output logic            mem_stall_ao,

  output logic            valid_o,
  output logic [4:0]      rd_idx_o,
  output logic            rd_wr_en_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            misaligned_o
);

  mem_state_e      state_q, state_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic            valid_q, valid_d;
  logic [4:0]      rd_idx_q, rd_idx_d;
  logic            rd_wr_en_q, rd_wr_en_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            misaligned_q, misaligned_d;

  logic [2:0]      off;
  logic            memop;
  logic            misaligned;
  logic            access;
  logic            rsp_done;
  logic [XLEN-1:0] align_src;
  logic [XLEN-1:0] load_data;

  assign off        = alu_res_i[2:0];
  assign memop      = valid_i & (mem_rd_i | mem_wr_i);
  assign misaligned = memop & is_misaligned(mem_width_1h_i, off);
  assign access     = memop & ~misaligned;

  // Address-side outputs follow the inputs, which upstream holds while we stall.
  assign dmem.req   = access & (state_q == ST_IDLE);
  assign dmem.we    = mem_wr_i;
  assign dmem.be    = width_mask(mem_width_1h_i) << off;
  assign dmem.addr  = {alu_res_i[XLEN-1:3], 3'b000};
  assign dmem.wdata = rs2_data_i << {off, 3'b000};

  // Access completes this cycle only if the output register may load.
  assign rsp_done = ((state_q == ST_WAIT_RSP) & dmem.rvalid) | (state_q == ST_HOLD);

  assign mem_stall_ao = access
                      & ~((state_q == ST_WAIT_RSP) & dmem.rvalid)
                      & ~((state_q == ST_HOLD) & ~stall_i);

  assign align_src = (state_q == ST_HOLD) ? buf_q : dmem.rdata;

  load_align_unit u_align (
    .rdata_i    (align_src),
    .off_i      (off),
    .width_1h_i (mem_width_1h_i),
    .sign_i     (mem_sign_i),
    .result_o   (load_data)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dmem.req && dmem.gnt) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (dmem.rvalid) begin
          if (stall_i) begin
            state_d = ST_HOLD;
            buf_d   = dmem.rdata;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (!stall_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d      = valid_q;
    rd_idx_d     = rd_idx_q;
    rd_wr_en_d   = rd_wr_en_q;
    rd_data_d    = rd_data_q;
    misaligned_d = misaligned_q;
    if (!stall_i) begin
      if (!access) begin
        valid_d      = valid_i;
        rd_idx_d     = rd_idx_i;
        rd_wr_en_d   = rd_wr_en_i & valid_i & ~misaligned & ~(memop & mem_wr_i);
        rd_data_d    = rd_data_i;
        misaligned_d = misaligned;
      end else if (rsp_done) begin
        valid_d      = 1'b1;
        rd_idx_d     = rd_idx_i;
        rd_wr_en_d   = rd_wr_en_i & ~mem_wr_i;
        rd_data_d    = mem_wr_i ? rd_data_i : load_data;
        misaligned_d = 1'b0;
      end else begin
        // Access still outstanding: emit a bubble.
        valid_d      = 1'b0;
        rd_wr_en_d   = 1'b0;
        misaligned_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      valid_q      <= 1'b0;
      rd_idx_q     <= '0;
      rd_wr_en_q   <= 1'b0;
      rd_data_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      valid_q      <= valid_d;
      rd_idx_q     <= rd_idx_d;
      rd_wr_en_q   <= rd_wr_en_d;
      rd_data_q    <= rd_data_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign valid_o      = valid_q;
  assign rd_idx_o     = rd_idx_q;
  assign rd_wr_en_o   = rd_wr_en_q;
  assign rd_data_o    = rd_data_q;
  assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  logic        stall_i;
  logic        valid_i;
  logic [63:0] alu_res_i;
  logic [63:0] rs2_data_i;
  logic [63:0] rd_data_i;
  logic [4:0]  rd_idx_i;
  logic        rd_wr_en_i;
  logic [3:0]  mem_width_1h_i;
  logic        mem_rd_i;
  logic        mem_wr_i;
  logic        mem_sign_i;
  logic        mem_stall_ao;
  logic        valid_o;
  logic [4:0]  rd_idx_o;
  logic        rd_wr_en_o;
  logic [63:0] rd_data_o;
  logic        misaligned_o;

  int checks = 0;
  int errors = 0;

  memory_stage_if dmem ();

  memory_stage dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .stall_i        (stall_i),
    .valid_i        (valid_i),
    .alu_res_i      (alu_res_i),
    .rs2_data_i     (rs2_data_i),
    .rd_data_i      (rd_data_i),
    .rd_idx_i       (rd_idx_i),
    .rd_wr_en_i     (rd_wr_en_i),
    .mem_width_1h_i (mem_width_1h_i),
    .mem_rd_i       (mem_rd_i),
    .mem_wr_i       (mem_wr_i),
    .mem_sign_i     (mem_sign_i),
    .dmem           (dmem.master),
    .mem_stall_ao   (mem_stall_ao),
    .valid_o        (valid_o),
    .rd_idx_o       (rd_idx_o),
    .rd_wr_en_o     (rd_wr_en_o),
    .rd_data_o      (rd_data_o),
    .misaligned_o   (misaligned_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clear_inputs();
    stall_i        = 1'b0;
    valid_i        = 1'b0;
    alu_res_i      = '0;
    rs2_data_i     = '0;
    rd_data_i      = '0;
    rd_idx_i       = '0;
    rd_wr_en_i     = 1'b0;
    mem_width_1h_i = WIDTH_B;
    mem_rd_i       = 1'b0;
    mem_wr_i       = 1'b0;
    mem_sign_i     = 1'b0;
    dmem.gnt       = 1'b0;
    dmem.rvalid    = 1'b0;
    dmem.rdata     = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    tick();
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid_o); end
    checks++; if (rd_data_o !== 64'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data_o); end
    checks++; if (misaligned_o !== 1'b0 || rd_wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_flags got mis=%0b wr=%0b want 0 0", misaligned_o, rd_wr_en_o); end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_lb();
    valid_i = 1'b1; alu_res_i = 64'h1003; mem_rd_i = 1'b1; mem_width_1h_i = WIDTH_B;
    mem_sign_i = 1'b1; rd_idx_i = 5'd5; rd_wr_en_i = 1'b1; dmem.gnt = 1'b1;
    #1;
    checks++; if (dmem.req !== 1'b1 || dmem.we !== 1'b0) begin errors++; $display("FAIL lb_req got req=%0b we=%0b want 1 0", dmem.req, dmem.we); end
    checks++; if (dmem.addr !== 64'h1000 || dmem.be !== 8'h08) begin errors++; $display("FAIL lb_addr_be got %h %h want 1000 08", dmem.addr, dmem.be); end
    checks++; if (mem_stall_ao !== 1'b1) begin errors++; $display("FAIL lb_stall_req got %0b want 1", mem_stall_ao); end
    tick();
    dmem.gnt = 1'b0; dmem.rvalid = 1'b1; dmem.rdata = 64'h0000_0000_8000_0000;
    #1;
    checks++; if (dmem.req !== 1'b0 || mem_stall_ao !== 1'b0) begin errors++; $display("FAIL lb_rsp_cycle got req=%0b stall=%0b want 0 0", dmem.req, mem_stall_ao); end
    tick();
    dmem.rvalid = 1'b0;
    checks++; if (rd_data_o !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffffffffffff80", rd_data_o); end
    checks++; if (valid_o !== 1'b1 || rd_wr_en_o !== 1'b1 || rd_idx_o !== 5'd5) begin errors++; $display("FAIL lb_ctrl got v=%0b wr=%0b idx=%0d want 1 1 5", valid_o, rd_wr_en_o, rd_idx_o); end
    clear_inputs();
  endtask

  task automatic test_store_sh();
    valid_i = 1'b1; alu_res_i = 64'h2006; mem_wr_i = 1'b1; mem_width_1h_i = WIDTH_H;
    rs2_data_i = 64'h1234; rd_idx_i = 5'd7; rd_wr_en_i = 1'b1; dmem.gnt = 1'b1;
    #1;
    checks++; if (dmem.be !== 8'hC0 || dmem.we !== 1'b1) begin errors++; $display("FAIL sh_be_we got %h %0b want c0 1", dmem.be, dmem.we); end
    checks++; if (dmem.wdata !== 64'h1234_0000_0000_0000) begin errors++; $display("FAIL sh_wdata got %h want 1234000000000000", dmem.wdata); end
    checks++; if (dmem.addr !== 64'h2000 || dmem.req !== 1'b1) begin errors++; $display("FAIL sh_addr got %h req=%0b want 2000 1", dmem.addr, dmem.req); end
    tick();
    dmem.gnt = 1'b0; dmem.rvalid = 1'b1;
    tick();
    checks++; if (valid_o !== 1'b1 || rd_wr_en_o !== 1'b0) begin errors++; $display("FAIL sh_result got v=%0b wr=%0b want 1 0", valid_o, rd_wr_en_o); end
    clear_inputs();
  endtask

  task automatic test_misaligned();
    valid_i = 1'b1; alu_res_i = 64'h3002; mem_rd_i = 1'b1; mem_width_1h_i = WIDTH_W;
    rd_idx_i = 5'd9; rd_wr_en_i = 1'b1; dmem.gnt = 1'b1;
    #1;
    checks++; if (dmem.req !== 1'b0 || mem_stall_ao !== 1'b0) begin errors++; $display("FAIL lw_mis_noreq got req=%0b stall=%0b want 0 0", dmem.req, mem_stall_ao); end
    tick();
    checks++; if (misaligned_o !== 1'b1 || valid_o !== 1'b1 || rd_wr_en_o !== 1'b0) begin errors++; $display("FAIL lw_mis_out got mis=%0b v=%0b wr=%0b want 1 1 0", misaligned_o, valid_o, rd_wr_en_o); end
    clear_inputs();
    valid_i = 1'b1; rd_data_i = 64'hDEAD_BEEF; rd_idx_i = 5'd3; rd_wr_en_i = 1'b1;
    tick();
    checks++; if (rd_data_o !== 64'hDEAD_BEEF || misaligned_o !== 1'b0 || rd_wr_en_o !== 1'b1) begin errors++; $display("FAIL passthru got %h mis=%0b wr=%0b want deadbeef 0 1", rd_data_o, misaligned_o, rd_wr_en_o); end
    clear_inputs();
  endtask

  task automatic test_ld_delayed();
    int  stall_cnt;
    bit  done;
    stall_cnt = 0;
    done      = 1'b0;
    valid_i = 1'b1; alu_res_i = 64'h4000; mem_rd_i = 1'b1; mem_width_1h_i = WIDTH_D;
    mem_sign_i = 1'b1; rd_idx_i = 5'd12; rd_wr_en_i = 1'b1;
    for (int c = 0; c < 10 && !done; c++) begin
      dmem.gnt    = (c == 2);
      dmem.rvalid = (c == 5);
      dmem.rdata  = (c == 5) ? 64'hF123_4567_89AB_CDEF : 64'h0;
      #1;
      if (mem_stall_ao) stall_cnt++;
      tick();
      if (c == 5) done = 1'b1;
      else begin
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ld_bubble c=%0d got v=%0b want 0", c, valid_o); end
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL ld_timeout got done=0 want 1"); end
    checks++; if (stall_cnt !== 5) begin errors++; $display("FAIL ld_stall_cycles got %0d want 5", stall_cnt); end
    checks++; if (valid_o !== 1'b1 || rd_data_o !== 64'hF123_4567_89AB_CDEF) begin errors++; $display("FAIL ld_data got v=%0b %h want 1 f123456789abcdef", valid_o, rd_data_o); end
    clear_inputs();
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ld_single_pulse got %0b want 0", valid_o); end
  endtask

  task automatic test_lwu_hold();
    valid_i = 1'b1; alu_res_i = 64'h5000; mem_rd_i = 1'b1; mem_width_1h_i = WIDTH_W;
    mem_sign_i = 1'b0; rd_idx_i = 5'd14; rd_wr_en_i = 1'b1; dmem.gnt = 1'b1;
    tick();
    dmem.gnt = 1'b0; dmem.rvalid = 1'b1; dmem.rdata = 64'h0000_0000_FFFF_FFFF; stall_i = 1'b1;
    #1;
    checks++; if (mem_stall_ao !== 1'b0) begin errors++; $display("FAIL lwu_rsp_stall got %0b want 0", mem_stall_ao); end
    tick();
    dmem.rvalid = 1'b0; dmem.rdata = 64'hAAAA_5555_AAAA_5555; dmem.gnt = 1'b1;
    #1;
    checks++; if (dmem.req !== 1'b0 || mem_stall_ao !== 1'b1) begin errors++; $display("FAIL lwu_hold_comb got req=%0b stall=%0b want 0 1", dmem.req, mem_stall_ao); end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL lwu_hold_out got v=%0b want 0", valid_o); end
    stall_i = 1'b0;
    #1;
    checks++; if (dmem.req !== 1'b0 || mem_stall_ao !== 1'b0) begin errors++; $display("FAIL lwu_release got req=%0b stall=%0b want 0 0", dmem.req, mem_stall_ao); end
    tick();
    checks++; if (valid_o !== 1'b1 || rd_data_o !== 64'h0000_0000_FFFF_FFFF || rd_idx_o !== 5'd14) begin errors++; $display("FAIL lwu_data got v=%0b %h idx=%0d want 1 00000000ffffffff 14", valid_o, rd_data_o, rd_idx_o); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_access();
    valid_i = 1'b1; alu_res_i = 64'h6000; mem_rd_i = 1'b1; mem_width_1h_i = WIDTH_D;
    rd_idx_i = 5'd20; rd_wr_en_i = 1'b1; dmem.gnt = 1'b1;
    tick();
    dmem.gnt = 1'b0;
    rst_ni = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0 || rd_data_o !== 64'h0 || rd_idx_o !== 5'd0) begin errors++; $display("FAIL rst_mid_out got v=%0b %h idx=%0d want 0 0 0", valid_o, rd_data_o, rd_idx_o); end
    tick();
    rst_ni = 1'b1;
    valid_i = 1'b0; mem_rd_i = 1'b0; rd_wr_en_i = 1'b0;
    dmem.rvalid = 1'b1; dmem.rdata = 64'h1111_2222_3333_4444;
    tick();
    dmem.rvalid = 1'b0;
    checks++; if (valid_o !== 1'b0 || rd_data_o !== 64'h0) begin errors++; $display("FAIL rst_late_rvalid got v=%0b %h want 0 0", valid_o, rd_data_o); end
    valid_i = 1'b1; mem_rd_i = 1'b1; alu_res_i = 64'h7000; dmem.gnt = 1'b1;
    #1;
    checks++; if (dmem.req !== 1'b1) begin errors++; $display("FAIL rst_idle_req got %0b want 1", dmem.req); end
    clear_inputs();
  endtask

  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    test_reset();
    test_lb();
    test_store_sh();
    test_misaligned();
    test_ld_delayed();
    test_lwu_hold();
    test_reset_mid_access();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
